// File: rtl/fk_mac_sequencer_if.sv
// Bus bundle between the filter front end and the 3-tap history/MAC sequencer.
// ovr_count is present only when OVERRUN_CNT_EN is defined.
interface fk_mac_sequencer_if #(
  parameter int W = 25
) ();
  logic         sample_valid;
  logic [W-1:0] sample_in;
  logic         clear_hist;
  logic [W-1:0] fk;
  logic [W-1:0] fk_1;
  logic [W-1:0] fk_2;
  logic [1:0]   mux_sel;
  logic         acc_clr;
  logic         acc_en;
  logic         busy;
  logic         done;
  logic         overrun;
`ifdef OVERRUN_CNT_EN
  logic [7:0]   ovr_count;
`endif

  modport master (
    output sample_valid, sample_in, clear_hist,
`ifdef OVERRUN_CNT_EN
    input  ovr_count,
`endif
    input  fk, fk_1, fk_2, mux_sel, acc_clr, acc_en, busy, done, overrun
  );

  modport slave (
    input  sample_valid, sample_in, clear_hist,
`ifdef OVERRUN_CNT_EN
    output ovr_count,
`endif
    output fk, fk_1, fk_2, mux_sel, acc_clr, acc_en, busy, done, overrun
  );
endinterface

// File: rtl/fk_mac_sequencer.sv
// fk_mac_sequencer: owns the f[k]/f[k-1]/f[k-2] history and sequences the Fk mux and MAC per sample.
// Build macro OVERRUN_CNT_EN adds the saturating dropped-sample counter ovr_count.
module fk_mac_sequencer #(
  parameter int W       = 25,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  fk_mac_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TAP0  = 3'd1,
    ST_TAP1  = 3'd2,
    ST_TAP2  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0] mux_sel;
    logic       acc_en;
    logic       acc_clr;
    logic       busy;
    logic       done;
  } outs_t;

  localparam logic [3:0] LAT_C = 4'(MAC_LAT);

  state_t       state_r;
  state_t       next_s;
  logic [3:0]   drain_r;
  logic [W-1:0] fk_r;
  logic [W-1:0] fk_1_r;
  logic [W-1:0] fk_2_r;
  outs_t        outs_r;
  logic         overrun_r;
  logic         open_s;
  logic         accept_s;

  function automatic outs_t decode_f(input state_t st);
    outs_t o;
    o.mux_sel = 2'b11;
    o.acc_en  = 1'b0;
    o.acc_clr = 1'b0;
    o.busy    = 1'b0;
    o.done    = 1'b0;
    case (st)
      ST_TAP0: begin
        o.mux_sel = 2'b00;
        o.acc_en  = 1'b1;
        o.acc_clr = 1'b1;
        o.busy    = 1'b1;
      end
      ST_TAP1: begin
        o.mux_sel = 2'b01;
        o.acc_en  = 1'b1;
        o.busy    = 1'b1;
      end
      ST_TAP2: begin
        o.mux_sel = 2'b10;
        o.acc_en  = 1'b1;
        o.busy    = 1'b1;
      end
      ST_DRAIN: o.busy    = 1'b1;
      ST_DONE:  o.done    = 1'b1;
      default:  o.mux_sel = 2'b11;
    endcase
    return o;
  endfunction

  function automatic state_t next_state_f(input state_t st, input logic [3:0] drain,
                                          input logic accept);
    state_t nx;
    case (st)
      ST_IDLE:  if (accept) nx = ST_TAP0; else nx = ST_IDLE;
      ST_TAP0:  nx = ST_TAP1;
      ST_TAP1:  nx = ST_TAP2;
      ST_TAP2:  if (LAT_C == 4'd0) nx = ST_DONE; else nx = ST_DRAIN;
      ST_DRAIN: if (drain == 4'd0) nx = ST_DONE; else nx = ST_DRAIN;
      ST_DONE:  if (accept) nx = ST_TAP0; else nx = ST_IDLE;
      default:  nx = ST_IDLE;
    endcase
    return nx;
  endfunction

  // New samples and history clears are only honoured while no computation is in flight.
  assign open_s   = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign accept_s = open_s && bus.sample_valid;
  assign next_s   = next_state_f(state_r, drain_r, accept_s);

  // Sequencer state, drain counter, history and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      drain_r   <= 4'd0;
      fk_r      <= '0;
      fk_1_r    <= '0;
      fk_2_r    <= '0;
      outs_r    <= decode_f(ST_IDLE);
      overrun_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      outs_r    <= decode_f(next_s);
      overrun_r <= outs_r.busy & bus.sample_valid;

      // Counter is preloaded on TAP2 so DRAIN lasts exactly MAC_LAT cycles.
      if (state_r == ST_TAP2) begin
        drain_r <= LAT_C - 4'd1;
      end else if ((state_r == ST_DRAIN) && (drain_r != 4'd0)) begin
        drain_r <= drain_r - 4'd1;
      end else begin
        drain_r <= drain_r;
      end

      if (accept_s) begin
        fk_r   <= bus.sample_in;
        fk_1_r <= bus.clear_hist ? '0 : fk_r;
        fk_2_r <= bus.clear_hist ? '0 : fk_1_r;
      end else if (open_s && bus.clear_hist) begin
        fk_r   <= '0;
        fk_1_r <= '0;
        fk_2_r <= '0;
      end else begin
        fk_r   <= fk_r;
        fk_1_r <= fk_1_r;
        fk_2_r <= fk_2_r;
      end
    end
  end

  assign bus.fk      = fk_r;
  assign bus.fk_1    = fk_1_r;
  assign bus.fk_2    = fk_2_r;
  assign bus.mux_sel = outs_r.mux_sel;
  assign bus.acc_en  = outs_r.acc_en;
  assign bus.acc_clr = outs_r.acc_clr;
  assign bus.busy    = outs_r.busy;
  assign bus.done    = outs_r.done;
  assign bus.overrun = overrun_r;

`ifdef OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_r;

  // Dropped-sample counter advances with the same condition that raises the overrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt_r <= 8'd0;
    end else if (outs_r.busy && bus.sample_valid && (ovr_cnt_r != 8'hFF)) begin
      ovr_cnt_r <= ovr_cnt_r + 8'd1;
    end else begin
      ovr_cnt_r <= ovr_cnt_r;
    end
  end

  assign bus.ovr_count = ovr_cnt_r;
`else
  // Without the counter only the overrun pulse reports dropped samples.
`endif

endmodule

// File: tb/tb_fk_mac_sequencer.sv
// Directed self-checking bench for fk_mac_sequencer (MAC_LAT=2); ovr_count checks follow OVERRUN_CNT_EN.
module tb_fk_mac_sequencer;
  localparam int W      = 25;
  localparam int LAT    = 2;
  localparam int DONE_C = 4 + LAT;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  fk_mac_sequencer_if #(.W(W)) bus ();

  fk_mac_sequencer #(.W(W), .MAC_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hist(input string tag, input int a, input int b, input int c);
    check_val({tag, " fk"},   32'(bus.fk),   32'(a));
    check_val({tag, " fk_1"}, 32'(bus.fk_1), 32'(b));
    check_val({tag, " fk_2"}, 32'(bus.fk_2), 32'(c));
  endtask

  // One sample accepted in C0; optional extra sample_valid during busy cycle inj.
  task automatic run_seq(input int val, input int inj);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 25'(val);
    for (int c = 1; c <= DONE_C + 1; c++) begin
      step();
      bus.sample_valid = (c == inj) ? 1'b1 : 1'b0;
      if (c == inj) bus.sample_in = 25'd99;
      check_val($sformatf("s%0d c%0d mux_sel", val, c), 32'(bus.mux_sel),
                (c <= 3) ? 32'(c - 1) : 32'd3);
      check_val($sformatf("s%0d c%0d acc_en", val, c), 32'(bus.acc_en), 32'(c <= 3));
      check_val($sformatf("s%0d c%0d acc_clr", val, c), 32'(bus.acc_clr), 32'(c == 1));
      check_val($sformatf("s%0d c%0d busy", val, c), 32'(bus.busy), 32'(c < DONE_C));
      check_val($sformatf("s%0d c%0d done", val, c), 32'(bus.done), 32'(c == DONE_C));
      check_val($sformatf("s%0d c%0d overrun", val, c), 32'(bus.overrun),
                32'((inj > 0) && (c == inj + 1)));
      check_val($sformatf("s%0d c%0d fk", val, c), 32'(bus.fk), 32'(val));
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = 25'd0;
    bus.clear_hist   = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_hist("reset", 0, 0, 0);
    check_val("reset mux_sel", 32'(bus.mux_sel), 32'd3);
    check_val("reset busy", 32'(bus.busy), 32'd0);
    check_val("reset done", 32'(bus.done), 32'd0);
    check_val("reset acc_en", 32'(bus.acc_en), 32'd0);
    check_val("reset overrun", 32'(bus.overrun), 32'd0);
    step();
    check_val("idle mux_sel", 32'(bus.mux_sel), 32'd3);

    // Samples 5, 7, 9 spaced 10 cycles apart.
    run_seq(5, 0);
    repeat (3) step();
    check_hist("after 5", 5, 0, 0);
    run_seq(7, 0);
    repeat (3) step();
    run_seq(9, 0);
    repeat (3) step();
    check_hist("after 9", 9, 7, 5);

    // Sample arriving in C2 is dropped and flagged.
    run_seq(11, 2);
    check_hist("after ovr", 11, 9, 7);
`ifdef OVERRUN_CNT_EN
    check_val("ovr_count one", 32'(bus.ovr_count), 32'd1);
`endif
    repeat (3) step();

    // Held sample_valid: accepts only in DONE, done every DONE_C cycles.
    bus.sample_valid = 1'b1;
    bus.sample_in    = 25'd20;
    for (int c = 1; c <= 5 * DONE_C; c++) begin
      step();
      bus.sample_in = 25'(100 + c);
      if (c == 5 * DONE_C) bus.sample_valid = 1'b0;
      check_val($sformatf("held c%0d done", c), 32'(bus.done), 32'((c % DONE_C) == 0));
      check_val($sformatf("held c%0d busy", c), 32'(bus.busy), 32'((c % DONE_C) != 0));
      check_val($sformatf("held c%0d overrun", c), 32'(bus.overrun),
                32'((c % DONE_C) != 1));
    end
    check_hist("held", 124, 118, 112);
`ifdef OVERRUN_CNT_EN
    check_val("ovr_count held", 32'(bus.ovr_count), 32'd26);
`endif
    repeat (2) step();

    // clear_hist together with an accepted sample.
    run_seq(1, 0);
    run_seq(2, 0);
    run_seq(4, 0);
    check_hist("pre clear", 4, 2, 1);
    bus.clear_hist   = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 25'd3;
    step();
    bus.sample_valid = 1'b0;
    check_hist("clear+accept", 3, 0, 0);
    check_val("clear+accept busy", 32'(bus.busy), 32'd1);
    step();
    bus.clear_hist = 1'b0;
    check_hist("clear busy ignored", 3, 0, 0);
    repeat (6) step();
    run_seq(6, 0);
    check_hist("pre clear only", 6, 3, 0);
    bus.clear_hist = 1'b1;
    step();
    bus.clear_hist = 1'b0;
    check_hist("clear only", 0, 0, 0);
    check_val("clear only busy", 32'(bus.busy), 32'd0);

    // Reset while in TAP1 aborts without a done pulse.
    bus.sample_valid = 1'b1;
    bus.sample_in    = 25'd50;
    step();
    bus.sample_valid = 1'b0;
    step();
    check_val("tap1 mux_sel", 32'(bus.mux_sel), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("abort busy", 32'(bus.busy), 32'd0);
    check_val("abort mux_sel", 32'(bus.mux_sel), 32'd3);
    check_val("abort acc_en", 32'(bus.acc_en), 32'd0);
    check_hist("abort", 0, 0, 0);
`ifdef OVERRUN_CNT_EN
    check_val("abort ovr_count", 32'(bus.ovr_count), 32'd0);
`endif
    for (int c = 1; c <= 8; c++) begin
      step();
      check_val($sformatf("abort c%0d done", c), 32'(bus.done), 32'd0);
      check_val($sformatf("abort c%0d busy", c), 32'(bus.busy), 32'd0);
    end

`ifdef OVERRUN_CNT_EN
    // Saturation of the dropped-sample counter.
    bus.sample_valid = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (c == 240) check_val("ovr_count 200", 32'(bus.ovr_count), 32'd200);
    end
    bus.sample_valid = 1'b0;
    repeat (8) step();
    check_val("ovr_count sat", 32'(bus.ovr_count), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
